// File: rtl/reg_mode_sequencer_pkg.sv
// Shared definitions for the mode-register sequencer.
// Holds the mode encodings, the FSM state type and the register's next-Y function.
package reg_mode_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_CPL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_SHL  = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // Behaviour of the 4-bit mode-select register for one clock edge.
  function automatic logic [3:0] next_y(input mode_t mode, input logic [3:0] d,
                                        input logic [3:0] y);
    logic [3:0] y_next;
    y_next = y;
    case (mode)
      MODE_HOLD: y_next = y;
      MODE_CPL:  y_next = ~y;
      MODE_SHR:  y_next = {d[3], y[3:1]};
      MODE_SHL:  y_next = {y[2:0], d[0]};
      default:   y_next = y;
    endcase
    return y_next;
  endfunction

endpackage

// File: rtl/reg_mode_sequencer_if.sv
// Command handshake bundle between the command source and the sequencer.
interface reg_mode_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [3:0]       cmd_data;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid, cmd_mode, cmd_data, cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_data, cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/reg_mode_sequencer_cmd_fifo.sv
// Small synchronous FIFO holding queued commands; head is visible combinationally
// so the sequencer can pop and load in the same edge.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/reg_mode_sequencer.sv
// Command-driven initiator for the 4-bit mode-select register.
// Define SEQ_CHECK_EN to build in the shadow model of Y and the sticky mismatch flag.
module reg_mode_sequencer
  import reg_mode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  reg_mode_sequencer_if.slave  cmd,
  output logic [1:0]           S,
  output logic [3:0]           D,
  input  logic [3:0]           Y,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           exp_y,
  output logic                 err
);
  localparam int FW = 6 + CNT_W;

  logic [FW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  seq_state_t       state_reg;
  mode_t            mode_reg;
  logic [3:0]       data_reg;
  logic [CNT_W-1:0] rem_reg;
  logic             done_reg;

  assign cmd.cmd_ready = !fifo_full;

  // A new command is taken from IDLE, or on the final cycle of the running one.
  assign pop = !fifo_empty && ((state_reg == ST_IDLE) || (rem_reg == '0));

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_cmd_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push    (cmd.cmd_valid),
    .wr_data ({cmd.cmd_mode, cmd.cmd_data, cmd.cmd_count}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      mode_reg  <= MODE_HOLD;
      data_reg  <= '0;
      rem_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mode_reg  <= mode_t'(head[FW-1 -: 2]);
            data_reg  <= head[CNT_W +: 4];
            rem_reg   <= head[CNT_W-1:0];
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rem_reg != '0) begin
            rem_reg <= rem_reg - 1'b1;
          end else begin
            done_reg <= 1'b1;
            if (!fifo_empty) begin
              mode_reg <= mode_t'(head[FW-1 -: 2]);
              data_reg <= head[CNT_W +: 4];
              rem_reg  <= head[CNT_W-1:0];
            end else begin
              mode_reg  <= MODE_HOLD;
              data_reg  <= '0;
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign S    = mode_reg;
  assign D    = data_reg;
  assign done = done_reg;
  assign busy = (state_reg == ST_RUN) || !fifo_empty;

`ifdef SEQ_CHECK_EN
  logic [3:0] exp_y_reg;
  logic       err_reg;

  // The model advances on the same edge as the real register, so Y and
  // exp_y_reg are compared before either moves.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      exp_y_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      exp_y_reg <= next_y(mode_reg, data_reg, exp_y_reg);
      if (Y != exp_y_reg) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign exp_y = exp_y_reg;
  assign err   = err_reg;
`else
  logic unused_y;
  assign unused_y = ^Y;
  assign exp_y    = 4'b0000;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_reg_mode_sequencer.sv
// Scoreboard bench for reg_mode_sequencer: a behavioural register closes the S/D -> Y loop.
`timescale 1ns/1ps
module tb_reg_mode_sequencer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
`ifdef SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [1:0] mode;
    logic [3:0] data;
    int         cycles;
    logic [3:0] y;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] S;
  logic [3:0] D, Y, exp_y, y_model;
  logic       busy, done, err;
  logic       y_force = 1'b0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  reg_mode_sequencer_if #(.CNT_W(CNT_W)) cmd_if ();

  reg_mode_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .cmd(cmd_if), .S(S), .D(D), .Y(Y),
    .busy(busy), .done(done), .exp_y(exp_y), .err(err)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the real mode-select register.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) y_model <= 4'b0000;
    else begin
      case (S)
        2'b01:   y_model <= ~y_model;
        2'b10:   y_model <= {D[3], y_model[3:1]};
        2'b11:   y_model <= {y_model[2:0], D[0]};
        default: y_model <= y_model;
      endcase
    end
  end
  assign Y = y_force ? 4'b0101 : y_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] m, input logic [3:0] d, input logic [3:0] c,
                      input logic [3:0] y_end);
    int waited = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_mode  = m;
    cmd_if.cmd_data  = d;
    cmd_if.cmd_count = c;
    while (!cmd_if.cmd_ready && waited < 64) begin
      tick(1);
      waited++;
    end
    if (!cmd_if.cmd_ready) begin
      check("push_timeout", cmd_if.cmd_ready, 1);
    end else begin
      sb.push_back('{m, d, int'(c) + 1, y_end});
      tick(1);
    end
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    sb.delete();
    tick(2);
    RESET = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      tick(1);
      n++;
    end
    tick(2);
    check({"drain_", tag}, sb.size(), 0);
  endtask

  // Monitor: one scoreboard entry retired per done pulse.
  initial begin
    int         run_cyc = 0;
    logic [1:0] last_s = 2'b00;
    logic [3:0] last_d = 4'b0000;
    exp_t       e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        run_cyc = 0;
        last_s  = 2'b00;
        last_d  = 4'b0000;
      end else begin
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", done, 0);
          end else begin
            e = sb.pop_front();
            $display("cmd done: mode=%b data=%b cycles=%0d y=%b exp_y=%b err=%b",
                     last_s, last_d, run_cyc, Y, exp_y, err);
            check("mon_mode", last_s, e.mode);
            check("mon_data", last_d, e.data);
            check("mon_cycles", run_cyc, e.cycles);
            check("mon_y", Y, e.y);
            check("mon_exp_y", exp_y, CHK ? e.y : 4'b0000);
            check("mon_err", err, 0);
          end
          run_cyc = 0;
        end
        if (S != 2'b00) begin
          run_cyc++;
          last_s = S;
          last_d = D;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] s_tab [6];
    logic [3:0] y_tab [6];
    s_tab = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};
    y_tab = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1100, 4'b1000};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_mode  = 2'b00;
    cmd_if.cmd_data  = 4'b0000;
    cmd_if.cmd_count = '0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    // Reset then idle.
    tick(5);
    check("rst_s", S, 2'b00);
    check("rst_d", D, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_y", Y, 4'b0000);
    check("rst_exp_y", exp_y, 4'b0000);
    check("rst_err", err, 0);

    // Single complement, count 0: two-cycle latency, one drive cycle.
    push(2'b01, 4'b1101, 4'd0, 4'b1111);
    check("lat_s_idle", S, 2'b00);
    check("lat_busy", busy, 1);
    tick(1);
    check("lat_s_run", S, 2'b01);
    check("lat_d_run", D, 4'b1101);
    tick(1);
    check("one_cycle_s", S, 2'b00);
    check("one_cycle_done", done, 1);
    check("one_cycle_y", Y, 4'b1111);
    tick(1);
    check("done_single", done, 0);
    drain("single");

    // Back-to-back shift right then shift left with no idle gap.
    do_reset();
    push(2'b10, 4'b1101, 4'd2, 4'b1110);
    push(2'b11, 4'b0000, 4'd1, 4'b1000);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b2b_s%0d", i), S, s_tab[i]);
      check($sformatf("b2b_y%0d", i), Y, y_tab[i]);
      tick(1);
    end
    drain("b2b");

    // Fill the FIFO: ready drops once DEPTH entries are queued; the sixth waits.
    do_reset();
    push(2'b10, 4'b1000, 4'd3, 4'b1111);
    push(2'b11, 4'b0000, 4'd3, 4'b0000);
    push(2'b01, 4'b0000, 4'd3, 4'b0000);
    push(2'b10, 4'b1000, 4'd3, 4'b1111);
    push(2'b11, 4'b0001, 4'd3, 4'b1111);
    check("full_ready", cmd_if.cmd_ready, 0);
    push(2'b01, 4'b0000, 4'd3, 4'b1111);
    drain("full");

    // Reset in the middle of a long command with two queued behind it.
    do_reset();
    push(2'b01, 4'b0000, 4'd15, 4'b0000);
    push(2'b10, 4'b1000, 4'd3, 4'b1111);
    push(2'b11, 4'b0001, 4'd3, 4'b1111);
    tick(3);
    RESET = 1'b1;
    sb.delete();
    #1;
    check("midrst_s", S, 2'b00);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    tick(1);
    RESET = 1'b0;
    tick(3);
    check("post_rst_s", S, 2'b00);
    check("post_rst_busy", busy, 0);
    push(2'b01, 4'b0000, 4'd0, 4'b1111);
    drain("after_rst");

    // Corrupt Y against the model: err latches and holds.
    check("pre_force_err", err, 0);
    y_force = 1'b1;
    tick(1);
    check("force_err", err, CHK);
    y_force = 1'b0;
    tick(3);
    check("err_sticky", err, CHK);
    check("force_exp_y", exp_y, CHK ? 4'b1111 : 4'b0000);
    do_reset();
    check("err_cleared", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
